// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: execute/write-back sequencer in front of an 8x8 register file.
// Accepts one instruction at a time over valid/ready, reads operands through
// RX/RY -> busX/busY, computes the result (single cycle, or 8-cycle
// shift-add for MUL) and writes it back through WEN/RW/busW.
//
// Ports
//   Clk          rising-edge clock
//   Rst          synchronous, active-high reset
//   instr_valid  instruction present on instr
//   instr_ready  high only in IDLE
//   instr        {op[11:9], rd[8:6], rs[5:3], rt[2:0]}
//   RX, RY       read addresses, taken from the latched rs/rt
//   busX, busY   combinational read data from the register file
//   WEN, RW, busW register file write port (WEN high only in WB)
//   done         one-cycle pulse in the write-back cycle
//   zero         registered: last written result was zero
module alu_issue_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [3+3*ADDR_W-1:0] instr,
  output logic [ADDR_W-1:0]     RX,
  output logic [ADDR_W-1:0]     RY,
  input  logic [DATA_W-1:0]     busX,
  input  logic [DATA_W-1:0]     busY,
  output logic                  WEN,
  output logic [ADDR_W-1:0]     RW,
  output logic [DATA_W-1:0]     busW,
  output logic                  done,
  output logic                  zero
);

  localparam int INSTR_W = 3 + 3*ADDR_W;
  localparam int CNT_W   = $clog2(DATA_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_WB   = 2'd3
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  state_t               state_q, state_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [DATA_W-1:0]    result_q, result_d;
  logic [ADDR_W-1:0]    rw_q, rw_d;
  logic                 zero_q, zero_d;
  logic [DATA_W-1:0]    mcand_q, mcand_d;
  logic [DATA_W-1:0]    mplier_q, mplier_d;
  logic [DATA_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [2:0]           op;
  logic [ADDR_W-1:0]    rd;

  // Single-cycle ALU; operands are unsigned, all results wrap mod 2^DATA_W.
  function automatic logic [DATA_W-1:0] alu_f(input logic [2:0]        f_op,
                                               input logic [DATA_W-1:0] x,
                                               input logic [DATA_W-1:0] y);
    logic [DATA_W-1:0] r;
    r = '0;
    case (f_op)
      OP_ADD:  r = x + y;
      OP_SUB:  r = x - y;
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_XOR:  r = x ^ y;
      OP_SLT:  r = {{(DATA_W-1){1'b0}}, (x < y)};
      OP_SHL:  r = x << y[2:0];
      default: r = '0;
    endcase
    return r;
  endfunction

  assign op = instr_q[INSTR_W-1 -: 3];
  assign rd = instr_q[3*ADDR_W-1 -: ADDR_W];

  assign instr_ready = (state_q == S_IDLE);
  assign RX          = instr_q[2*ADDR_W-1 -: ADDR_W];
  assign RY          = instr_q[ADDR_W-1:0];
  // Reset during WB suppresses the write at that very edge.
  assign WEN         = (state_q == S_WB) && !Rst;
  assign done        = (state_q == S_WB) && !Rst;
  assign RW          = rw_q;
  assign busW        = result_q;
  assign zero        = zero_q;

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    result_d = result_q;
    rw_d     = rw_q;
    zero_d   = zero_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      // IDLE: capture the whole instruction at the accept edge
      S_IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = S_EXEC;
        end
      end
      // EXEC: operands valid on busX/busY from the latched rs/rt
      S_EXEC: begin
        if (op == OP_MUL) begin
          mcand_d  = busX;
          mplier_d = busY;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_MUL;
        end else begin
          result_d = alu_f(op, busX, busY);
          rw_d     = rd;
          state_d  = S_WB;
        end
      end
      // MUL: one shift-add step per cycle, DATA_W steps total
      S_MUL: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          result_d = acc_d;
          rw_d     = rd;
          state_d  = S_WB;
        end
      end
      // WB: write port is live for this cycle only
      S_WB: begin
        zero_d  = (result_q == '0);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= S_IDLE;
      instr_q  <= '0;
      result_q <= '0;
      rw_q     <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      result_q <= result_d;
      rw_q     <= rw_d;
      zero_q   <= zero_d;
    end
  end

  // Multiplier working registers are always reloaded in EXEC before use.
  always_ff @(posedge Clk) begin
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    acc_q    <= acc_d;
    cnt_q    <= cnt_d;
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;
  localparam logic [2:0] AND = 3'b010;
  localparam logic [2:0] OR  = 3'b011;
  localparam logic [2:0] XOR = 3'b100;
  localparam logic [2:0] SLT = 3'b101;
  localparam logic [2:0] SHL = 3'b110;
  localparam logic [2:0] MUL = 3'b111;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [11:0] instr;
  logic [2:0]  RX, RY, RW;
  logic [7:0]  busX, busY, busW;
  logic        WEN, done, zero;

  logic        pl_en;
  logic [2:0]  pl_addr;
  logic [7:0]  pl_data;
  logic [7:0]  rf [0:7] = '{default: 8'h00};

  int n_vec = 0;
  int n_err = 0;

  alu_issue_ctrl #(.DATA_W(8), .ADDR_W(3)) dut (
    .Clk(Clk), .Rst(Rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .RX(RX), .RY(RY), .busX(busX), .busY(busY),
    .WEN(WEN), .RW(RW), .busW(busW), .done(done), .zero(zero)
  );

  always #5 Clk = ~Clk;

  // Register file model: combinational reads, r0 hard-wired to zero.
  assign busX = rf[RX];
  assign busY = rf[RY];
  always @(posedge Clk) begin
    if (WEN && RW != 3'd0) rf[RW] <= busW;
    else if (pl_en && pl_addr != 3'd0) rf[pl_addr] <= pl_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic load(input logic [2:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    step();
    pl_en = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] rd,
                       input logic [2:0] rs, input logic [2:0] rt);
    instr_valid = 1'b1;
    instr = {op, rd, rs, rt};
    step();
    instr_valid = 1'b0;
  endtask

  task automatic run_alu(input string tag, input logic [2:0] op, input logic [2:0] rd,
                         input logic [2:0] rs, input logic [2:0] rt,
                         input logic [7:0] exp, input logic expz);
    issue(op, rd, rs, rt);
    check({tag, ".exec_rx"}, RX, rs);
    check({tag, ".exec_ry"}, RY, rt);
    check({tag, ".exec_ready"}, instr_ready, 1'b0);
    check({tag, ".exec_wen"}, WEN, 1'b0);
    step();
    check({tag, ".wb_wen"}, WEN, 1'b1);
    check({tag, ".wb_done"}, done, 1'b1);
    check({tag, ".wb_rw"}, RW, rd);
    check({tag, ".wb_busw"}, busW, exp);
    step();
    check({tag, ".idle_ready"}, instr_ready, 1'b1);
    check({tag, ".idle_wen"}, WEN, 1'b0);
    check({tag, ".idle_busw_hold"}, busW, exp);
    check({tag, ".zero"}, zero, expz);
    if (rd != 3'd0) check({tag, ".rf"}, rf[rd], exp);
  endtask

  // hold=1 keeps instr_valid high with a changing instr throughout the op.
  task automatic run_mul(input string tag, input logic [2:0] rd, input logic [2:0] rs,
                         input logic [2:0] rt, input logic [7:0] exp, input logic hold);
    issue(MUL, rd, rs, rt);
    for (int i = 0; i < 10; i++) begin
      if (hold) begin
        instr_valid = 1'b1;
        instr = {3'(i % 7), 3'd7, 3'd1, 3'd2};
      end
      check({tag, ".busy_ready"}, instr_ready, 1'b0);
      check({tag, ".wen_timing"}, WEN, (i == 9));
      if (i == 5) check({tag, ".rx_latched"}, RX, rs);
      if (i == 9) begin
        check({tag, ".wb_busw"}, busW, exp);
        check({tag, ".wb_rw"}, RW, rd);
        check({tag, ".wb_done"}, done, 1'b1);
        instr_valid = 1'b0;
      end
      step();
    end
    check({tag, ".idle_ready"}, instr_ready, 1'b1);
    check({tag, ".zero"}, zero, (exp == 8'h00));
    check({tag, ".rf"}, rf[rd], exp);
  endtask

  initial begin
    Rst = 1'b1; instr_valid = 1'b1; instr = {ADD, 3'd3, 3'd1, 3'd2};
    pl_en = 1'b0; pl_addr = 3'd0; pl_data = 8'h00;

    // Reset with a pending instruction: nothing may be accepted.
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst.wen", WEN, 1'b0);
      check("rst.done", done, 1'b0);
      check("rst.zero", zero, 1'b0);
      check("rst.ready", instr_ready, 1'b1);
      check("rst.rw", RW, 3'd0);
      check("rst.busw", busW, 8'h00);
      check("rst.rx", RX, 3'd0);
      check("rst.ry", RY, 3'd0);
    end
    Rst = 1'b0; instr_valid = 1'b0;
    step();
    check("post_rst.ready", instr_ready, 1'b1);
    check("post_rst.wen", WEN, 1'b0);

    // ADD with carry out discarded
    load(3'd1, 8'hF0); load(3'd2, 8'h20); load(3'd7, 8'h55);
    run_alu("add_wrap", ADD, 3'd3, 3'd1, 3'd2, 8'h10, 1'b0);

    // All single-cycle ops
    load(3'd1, 8'h0C); load(3'd2, 8'h0A);
    run_alu("sub", SUB, 3'd4, 3'd1, 3'd2, 8'h02, 1'b0);
    run_alu("and", AND, 3'd4, 3'd1, 3'd2, 8'h08, 1'b0);
    run_alu("or",  OR,  3'd4, 3'd1, 3'd2, 8'h0E, 1'b0);
    run_alu("xor", XOR, 3'd4, 3'd1, 3'd2, 8'h06, 1'b0);
    run_alu("slt_false", SLT, 3'd4, 3'd1, 3'd2, 8'h00, 1'b1);
    run_alu("slt_true",  SLT, 3'd4, 3'd2, 3'd1, 8'h01, 1'b0);
    load(3'd2, 8'h0B);
    run_alu("shl", SHL, 3'd4, 3'd1, 3'd2, 8'h60, 1'b0);
    load(3'd2, 8'hF4);
    run_alu("add_zero", ADD, 3'd4, 3'd1, 3'd2, 8'h00, 1'b1);
    // rd == rs: old r1 (0x0C) is read before the write lands
    run_alu("rd_eq_rs", ADD, 3'd1, 3'd1, 3'd1, 8'h18, 1'b0);

    // MUL with back-pressured producer holding valid and changing instr
    load(3'd4, 8'h0D); load(3'd5, 8'h13);
    run_mul("mul_hold", 3'd6, 3'd4, 3'd5, 8'hF7, 1'b1);
    check("mul_hold.r7_untouched", rf[7], 8'h55);
    step();
    check("mul_hold.no_second_accept", instr_ready, 1'b1);

    load(3'd1, 8'hFF); load(3'd2, 8'hFF);
    run_mul("mul_ff", 3'd5, 3'd1, 3'd2, 8'h01, 1'b0);

    // rd = 0: write still signalled, r0 stays zero when read back
    run_alu("rd0", ADD, 3'd0, 3'd1, 3'd2, 8'hFE, 1'b0);
    run_alu("r0_read", OR, 3'd3, 3'd0, 3'd0, 8'h00, 1'b1);

    // Reset in the fourth MUL cycle drops the op
    load(3'd2, 8'h03); load(3'd3, 8'h05); load(3'd4, 8'hAA);
    issue(MUL, 3'd4, 3'd2, 3'd3);
    for (int i = 0; i < 4; i++) begin
      check("mulrst.busy", instr_ready, 1'b0);
      step();
    end
    Rst = 1'b1;
    check("mulrst.wen_during_rst", WEN, 1'b0);
    step();
    Rst = 1'b0;
    check("mulrst.ready", instr_ready, 1'b1);
    check("mulrst.zero_cleared", zero, 1'b0);
    for (int i = 0; i < 10; i++) begin
      check("mulrst.no_wen", WEN, 1'b0);
      step();
    end
    check("mulrst.rd_unchanged", rf[4], 8'hAA);
    run_mul("mul_after_rst", 3'd4, 3'd2, 3'd3, 8'h0F, 1'b0);

    // Reset during WB blocks the write
    load(3'd4, 8'hAA);
    issue(ADD, 3'd4, 3'd2, 3'd3);
    step();
    Rst = 1'b1;
    #1;
    check("wbrst.wen_gated", WEN, 1'b0);
    check("wbrst.done_gated", done, 1'b0);
    step();
    Rst = 1'b0;
    check("wbrst.rd_unchanged", rf[4], 8'hAA);
    check("wbrst.ready", instr_ready, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Execute/write-back sequencer that sits directly upstream of the 8x8 register file.
- Accepts one instruction at a time over a valid/ready handshake and drives the read addresses RX/RY.
- Consumes the combinational read data busX/busY and computes the result, single-cycle or iterative for multiply.
- Writes the result back through WEN/RW/busW. Single-issue, no pipelining, so no hazards are possible.

Parameters:
- DATA_W, 8, operand/result width; must match the register file busW/busX/busY width.
- ADDR_W, 3, register address width; must match the register file RW/RX/RY width.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction present on instr.
- instr_ready  out  1  block can accept an instruction this cycle.
- instr  in  3+3*ADDR_W (12)  {op[11:9], rd[8:6], rs[5:3], rt[2:0]}.
- RX  out  ADDR_W  register file read address X; driven from latched rs.
- RY  out  ADDR_W  register file read address Y; driven from latched rt.
- busX  in  DATA_W  register file read data X; combinational from RX.
- busY  in  DATA_W  register file read data Y; combinational from RY.
- WEN  out  1  register file write enable.
- RW  out  ADDR_W  register file write address.
- busW  out  DATA_W  register file write data.
- done  out  1  one-cycle pulse in the write-back cycle.
- zero  out  1  registered flag; set when the last written result == 0.

Behaviour:
- Clock/reset: one clock (Clk). Rst is synchronous and active-high; all state is updated only on the rising edge of Clk.
- Reset values: state=IDLE; instr_ready=1; WEN=0; done=0; zero=0; RW=0; busW=0; RX=0; RY=0; latched instr=0; result=0.
- States:
  - IDLE: instr_ready=1. If instr_valid&&instr_ready at an edge, latch the full instr field and go to EXEC. Otherwise stay in IDLE.
  - EXEC (1 cycle): RX=rs and RY=rt, combinationally from the latched fields. Sample busX/busY at the end of the cycle.
    - op!=MUL: result <= f(busX,busY), then go to WB.
    - op==MUL: load mcand=busX, mplier=busY, acc=0, cnt=0, then go to MUL.
  - MUL (exactly DATA_W=8 cycles): each cycle, if mplier[0] then acc <= acc+mcand; then mcand <= mcand<<1, mplier <= mplier>>1, cnt <= cnt+1. After the cycle with cnt==7, result <= acc-final and go to WB.
  - WB (1 cycle): WEN=1, RW=rd, busW=result, done=1. The register file captures the write at the closing edge. zero <= (result==0) at that edge. Then go to IDLE.
- Opcodes (all arithmetic is mod 2^DATA_W; carry/borrow discarded):
  - 000 ADD: X+Y
  - 001 SUB: X-Y
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SLT: 1 if X<Y (unsigned), else 0
  - 110 SHL: X<<Y[2:0]
  - 111 MUL: low DATA_W bits of X*Y
- Latency: accept edge to write edge is 2 cycles for non-MUL and 10 cycles for MUL. instr_ready returns high in the cycle after WB. Throughput is one non-MUL instruction per 3 cycles.
- Handshake:
  - instr_ready is low in EXEC, MUL and WB.
  - instr_valid asserted while not ready is ignored and not buffered; the producer must hold it.
  - instr is only sampled at the accept edge; later changes do not affect the in-flight op.
- Outside WB: WEN=0, done=0, busW and RW hold their last values.
- rd=0: WEN is still asserted and done still pulses. The register file discards the write (r0 stays 0). zero reflects the computed result, not r0.
- Source equals destination (e.g. rd==rs): operands are read in EXEC before the WB write, so the old value is used.
- Rst in any state, including mid-MUL or during WB: takes priority over everything. Next cycle is IDLE with WEN=0. The in-flight instruction is dropped and no write occurs at that edge.
- Rst together with instr_valid: the instruction is not accepted.

Test Plan:
- Reset/idle: assert Rst 2 cycles with instr_valid=1 -> WEN=0, done=0, zero=0, instr_ready=1, no accept.
- ADD wrap: r1=0xF0, r2=0x20; issue ADD rd=3 rs=1 rt=2 -> RX=1/RY=2 in EXEC; WEN=1, RW=3, busW=0x10 exactly 2 cycles after accept; ready high the cycle after.
- All ALU ops: with r1=0x0C, r2=0x0A:
  - SUB -> 0x02
  - AND -> 0x08
  - OR -> 0x0E
  - XOR -> 0x06
  - SLT -> 0x00
  - SLT with r1/r2 swapped -> 0x01
  - SHL with r2=0x0B -> 0x60
  - ADD r1+(r2=0xF4) -> zero=1
- MUL: r4=0x0D, r5=0x13; issue MUL rd=6 -> instr_ready low for 10 cycles; busW=0xF7 in the WB cycle at accept+10; zero=0. 0xFF*0xFF -> 0x01.
- Handshake/back-pressure: hold instr_valid with changing instr during EXEC/MUL -> no second accept; the in-flight result is unaffected. rd=0 -> WEN=1, RW=0, r0 reads 0 afterwards.
- Reset mid-MUL: assert Rst at MUL cycle 4 -> next cycle IDLE, WEN never asserted, destination register unchanged; next instruction executes normally.
